// File: rtl/reg_writeback_if.sv
// Bus bundle for reg_writeback: ALU and MDU result streams, decode hit queries,
// and the register-file write port.
interface reg_writeback_if #(
    parameter int PTR_W = 2
);
    logic             alu_valid;
    logic [4:0]       alu_dest;
    logic [31:0]      alu_data;
    logic             mdu_valid;
    logic             mdu_ready;
    logic [4:0]       mdu_dest;
    logic [31:0]      mdu_data;
    logic [4:0]       query1;
    logic [4:0]       query2;
    logic             hit1;
    logic             hit2;
    logic             regWrite;
    logic [4:0]       writeReg;
    logic [31:0]      writeData;
    logic [PTR_W:0]   fifo_count;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mdu_valid, mdu_dest, mdu_data,
        output query1, query2,
        input  mdu_ready, hit1, hit2,
        input  regWrite, writeReg, writeData, fifo_count
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mdu_valid, mdu_dest, mdu_data,
        input  query1, query2,
        output mdu_ready, hit1, hit2,
        output regWrite, writeReg, writeData, fifo_count
    );
endinterface

// File: rtl/reg_writeback.sv
// Register-file write arbiter: ALU results have priority, MDU results queue in a FIFO.
// Optional MDU_BYPASS_EN sends an MDU result straight to the write port when nothing else is pending.
module reg_writeback #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock_in,
    input  logic             reset,
    reg_writeback_if.slave   wb
);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic [4:0]       r_mem_dest [DEPTH];
    logic [31:0]      r_mem_data [DEPTH];

    logic             r_we_p0;
    logic [4:0]       r_wreg_p0;
    logic [31:0]      r_wdata_p0;

    logic w_ready;
    logic w_empty;
    logic w_alu_wr;
    logic w_pop;
    logic w_accept;
    logic w_bypass;
    logic w_push;
    logic w_hit1;
    logic w_hit2;

    // An entry is live when its distance from the read pointer is below the occupancy.
    function automatic logic entry_live(input logic [PTR_W-1:0] idx,
                                        input logic [PTR_W-1:0] rd,
                                        input logic [PTR_W:0]   cnt);
        logic [PTR_W-1:0] off;
        off = idx - rd;
        return {1'b0, off} < cnt;
    endfunction

    assign w_ready  = (r_count < DEPTH_C);
    assign w_empty  = (r_count == '0);
    assign w_alu_wr = wb.alu_valid && (wb.alu_dest != 5'd0);
    assign w_pop    = !w_alu_wr && !w_empty;
    assign w_accept = wb.mdu_valid && w_ready && (wb.mdu_dest != 5'd0);

`ifdef MDU_BYPASS_EN
    assign w_bypass = w_accept && w_empty && !w_alu_wr;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_accept && !w_bypass;

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_live(PTR_W'(i), r_rd_ptr, r_count)) begin
                if (r_mem_dest[i] == wb.query1) w_hit1 = 1'b1;
                if (r_mem_dest[i] == wb.query2) w_hit2 = 1'b1;
            end
        end
        if (r_we_p0 && (r_wreg_p0 == wb.query1)) w_hit1 = 1'b1;
        if (r_we_p0 && (r_wreg_p0 == wb.query2)) w_hit2 = 1'b1;
        if (wb.query1 == 5'd0) w_hit1 = 1'b0;
        if (wb.query2 == 5'd0) w_hit2 = 1'b0;
    end

    // FIFO storage is intentionally not reset; liveness comes from pointers and count.
    always_ff @(posedge clock_in) begin
        if (w_push) begin
            r_mem_dest[r_wr_ptr] <= wb.mdu_dest;
            r_mem_data[r_wr_ptr] <= wb.mdu_data;
        end
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Stage p0: registered register-file write port.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            r_we_p0    <= 1'b0;
            r_wreg_p0  <= 5'd0;
            r_wdata_p0 <= 32'd0;
        end else if (w_alu_wr) begin
            r_we_p0    <= 1'b1;
            r_wreg_p0  <= wb.alu_dest;
            r_wdata_p0 <= wb.alu_data;
        end else if (w_pop) begin
            r_we_p0    <= 1'b1;
            r_wreg_p0  <= r_mem_dest[r_rd_ptr];
            r_wdata_p0 <= r_mem_data[r_rd_ptr];
        end else if (w_bypass) begin
            r_we_p0    <= 1'b1;
            r_wreg_p0  <= wb.mdu_dest;
            r_wdata_p0 <= wb.mdu_data;
        end else begin
            r_we_p0    <= 1'b0;
        end
    end

    assign wb.mdu_ready  = w_ready;
    assign wb.hit1       = w_hit1;
    assign wb.hit2       = w_hit2;
    assign wb.regWrite   = r_we_p0;
    assign wb.writeReg   = r_wreg_p0;
    assign wb.writeData  = r_wdata_p0;
    assign wb.fifo_count = r_count;
endmodule

// File: tb/tb_reg_writeback.sv
// Testbench for reg_writeback: directed vector table, corner-case sequences,
// and randomized traffic against a queue-based reference model.
module tb_reg_writeback;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    reg_writeback_if #(.PTR_W(2)) bus();

    reg_writeback #(.DEPTH(4), .PTR_W(2)) dut (
        .clock_in (clk),
        .reset    (rst_n),
        .wb       (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit av, input int ad, input int adt,
                         input bit mv, input int md, input int mdt,
                         input int q1, input int q2);
        bus.alu_valid = av;
        bus.alu_dest  = 5'(ad);
        bus.alu_data  = 32'(adt);
        bus.mdu_valid = mv;
        bus.mdu_dest  = 5'(md);
        bus.mdu_data  = 32'(mdt);
        bus.query1    = 5'(q1);
        bus.query2    = 5'(q2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed vector table
    typedef struct {
        bit av; bit [4:0] ad; bit [31:0] adt;
        bit mv; bit [4:0] md; bit [31:0] mdt;
        bit [4:0] q1; bit [4:0] q2;
        bit ewe; bit [4:0] ereg; bit [31:0] edt;
        bit [2:0] ecnt; bit erdy; bit eh1; bit eh2;
    } vec_t;
    vec_t tv[$];

    function automatic void add(int av, int ad, int adt, int mv, int md, int mdt,
                                int q1, int q2, int ewe, int ereg, int edt,
                                int ecnt, int erdy, int eh1, int eh2);
        vec_t v;
        v.av = av[0];  v.ad = 5'(ad);   v.adt = 32'(adt);
        v.mv = mv[0];  v.md = 5'(md);   v.mdt = 32'(mdt);
        v.q1 = 5'(q1); v.q2 = 5'(q2);
        v.ewe = ewe[0]; v.ereg = 5'(ereg); v.edt = 32'(edt);
        v.ecnt = 3'(ecnt); v.erdy = erdy[0]; v.eh1 = eh1[0]; v.eh2 = eh2[0];
        tv.push_back(v);
    endfunction

    // Reference model: a plain queue of pending MDU results plus the write port
    typedef struct { logic [4:0] d; logic [31:0] v; } ent_t;
    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    function automatic void model_reset();
        mq.delete();
        m_we = 1'b0; m_reg = 5'd0; m_data = 32'd0;
    endfunction

    function automatic void model_step();
        ent_t e;
        bit rdy, acc, byp;
        rdy = (mq.size() < 4);
        acc = bus.mdu_valid && rdy && (bus.mdu_dest != 5'd0);
        byp = 1'b0;
        if (bus.alu_valid && bus.alu_dest != 5'd0) begin
            m_we = 1'b1; m_reg = bus.alu_dest; m_data = bus.alu_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_reg = e.d; m_data = e.v;
        end
`ifdef MDU_BYPASS_EN
        else if (acc) begin
            byp = 1'b1;
            m_we = 1'b1; m_reg = bus.mdu_dest; m_data = bus.mdu_data;
        end
`endif
        else begin
            m_we = 1'b0;
        end
        if (acc && !byp) begin
            e.d = bus.mdu_dest; e.v = bus.mdu_data;
            mq.push_back(e);
        end
    endfunction

    function automatic bit m_hit(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].d == q) return 1'b1;
        return m_we && (m_reg == q);
    endfunction

    task automatic check_model(input int cyc);
        string s;
        s = $sformatf("rand%0d", cyc);
        chk({s, ".regWrite"},   32'(bus.regWrite),   32'(m_we));
        chk({s, ".writeReg"},   32'(bus.writeReg),   32'(m_reg));
        chk({s, ".writeData"},  bus.writeData,       m_data);
        chk({s, ".fifo_count"}, 32'(bus.fifo_count), 32'(mq.size()));
        chk({s, ".mdu_ready"},  32'(bus.mdu_ready),  32'(mq.size() < 4));
        chk({s, ".hit1"},       32'(bus.hit1),       32'(m_hit(bus.query1)));
        chk({s, ".hit2"},       32'(bus.hit2),       32'(m_hit(bus.query2)));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        string s;
        add(1, 5, 'h1234, 0, 0, 0,       5, 0,   1, 5, 'h1234, 0, 1, 1, 0);
        add(1, 0, 'hFFFF, 0, 0, 0,       5, 0,   0, 5, 'h1234, 0, 1, 0, 0);
        add(1, 1, 'h11,   1, 8, 'h80,    8, 1,   1, 1, 'h11,   1, 1, 1, 1);
        add(1, 2, 'h22,   1, 9, 'h90,    9, 8,   1, 2, 'h22,   2, 1, 1, 1);
        add(1, 3, 'h33,   1, 10, 'hA0,   10, 3,  1, 3, 'h33,   3, 1, 1, 1);
        add(1, 4, 'h44,   1, 11, 'hB0,   11, 2,  1, 4, 'h44,   4, 0, 1, 0);
        add(1, 6, 'h66,   1, 12, 'hC0,   12, 6,  1, 6, 'h66,   4, 0, 0, 1);
        add(0, 0, 0,      0, 0, 0,       8, 11,  1, 8, 'h80,   3, 1, 1, 1);
        add(0, 0, 0,      1, 0, 'hDEAD,  0, 0,   1, 9, 'h90,   2, 1, 0, 0);
        add(0, 0, 0,      1, 13, 'hD0,   13, 10, 1, 10, 'hA0,  2, 1, 1, 1);
        add(1, 0, 'h5555, 0, 0, 0,       12, 13, 1, 11, 'hB0,  1, 1, 0, 1);
        add(0, 0, 0,      0, 0, 0,       13, 9,  1, 13, 'hD0,  0, 1, 1, 0);
        add(0, 0, 0,      0, 0, 0,       13, 0,  0, 13, 'hD0,  0, 1, 0, 0);

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 5, 5);
        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst.regWrite",   32'(bus.regWrite),   32'd0);
        chk("rst.writeReg",   32'(bus.writeReg),   32'd0);
        chk("rst.writeData",  bus.writeData,       32'd0);
        chk("rst.fifo_count", 32'(bus.fifo_count), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("rst.mdu_ready",  32'(bus.mdu_ready),  32'd1);
        chk("rst.hit1",       32'(bus.hit1),       32'd0);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].av, tv[i].ad, tv[i].adt, tv[i].mv, tv[i].md, tv[i].mdt, tv[i].q1, tv[i].q2);
            tick();
            s = $sformatf("vec%0d", i);
            chk({s, ".regWrite"},   32'(bus.regWrite),   32'(tv[i].ewe));
            chk({s, ".writeReg"},   32'(bus.writeReg),   32'(tv[i].ereg));
            chk({s, ".writeData"},  bus.writeData,       tv[i].edt);
            chk({s, ".fifo_count"}, 32'(bus.fifo_count), 32'(tv[i].ecnt));
            chk({s, ".mdu_ready"},  32'(bus.mdu_ready),  32'(tv[i].erdy));
            chk({s, ".hit1"},       32'(bus.hit1),       32'(tv[i].eh1));
            chk({s, ".hit2"},       32'(bus.hit2),       32'(tv[i].eh2));
        end

        // Fill three entries behind a busy ALU, then push and pop together across pointer wrap
        for (int k = 0; k < 3; k++) begin
            drive(1, 1 + k, 'h10 + k, 1, 16 + k, 'h110 + k, 0, 0);
            tick();
        end
        chk("wrap.fill_count", 32'(bus.fifo_count), 32'd3);
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 1, 19 + k, 'h113 + k, 0, 0);
            tick();
            s = $sformatf("wrap%0d", k);
            chk({s, ".regWrite"},   32'(bus.regWrite),   32'd1);
            chk({s, ".writeReg"},   32'(bus.writeReg),   32'(16 + k));
            chk({s, ".writeData"},  bus.writeData,       32'(32'h110 + k));
            chk({s, ".fifo_count"}, 32'(bus.fifo_count), 32'd3);
        end

        // Reset mid-stream with entries 22,23,24 buffered
        drive(1, 30, 'h3030, 0, 0, 0, 22, 24);
        #1;
        chk("midrst.pre_hit1", 32'(bus.hit1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst.regWrite",   32'(bus.regWrite),   32'd0);
        chk("midrst.fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("midrst.mdu_ready",  32'(bus.mdu_ready),  32'd1);
        chk("midrst.hit1",       32'(bus.hit1),       32'd0);
        chk("midrst.hit2",       32'(bus.hit2),       32'd0);
        drive(0, 0, 0, 0, 0, 0, 22, 24);
        tick();
        chk("midrst.held_regWrite", 32'(bus.regWrite), 32'd0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            s = $sformatf("postrst%0d", k);
            chk({s, ".regWrite"},   32'(bus.regWrite),   32'd0);
            chk({s, ".fifo_count"}, 32'(bus.fifo_count), 32'd0);
        end

        // MDU latency into an empty FIFO with ALU idle
        drive(0, 0, 0, 1, 3, 'hCAFE, 3, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 3, 0);
`ifdef MDU_BYPASS_EN
        chk("lat.e1_regWrite",   32'(bus.regWrite),   32'd1);
        chk("lat.e1_writeReg",   32'(bus.writeReg),   32'd3);
        chk("lat.e1_writeData",  bus.writeData,       32'hCAFE);
        chk("lat.e1_fifo_count", 32'(bus.fifo_count), 32'd0);
        tick();
        chk("lat.e2_regWrite",   32'(bus.regWrite),   32'd0);
`else
        chk("lat.e1_regWrite",   32'(bus.regWrite),   32'd0);
        chk("lat.e1_fifo_count", 32'(bus.fifo_count), 32'd1);
        chk("lat.e1_hit1",       32'(bus.hit1),       32'd1);
        tick();
        chk("lat.e2_regWrite",   32'(bus.regWrite),   32'd1);
        chk("lat.e2_writeReg",   32'(bus.writeReg),   32'd3);
        chk("lat.e2_writeData",  bus.writeData,       32'hCAFE);
`endif
        tick();
        chk("lat.retired_hit1", 32'(bus.hit1), 32'd0);

        // Randomized traffic against the reference model
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        model_reset();
        tick();
        for (int c = 0; c < 1500; c++) begin
            int alu_pct;
            alu_pct = ((c / 100) % 2 == 0) ? 85 : 25;
            drive($urandom_range(99) < alu_pct, $urandom_range(7), $urandom,
                  $urandom_range(99) < 55, $urandom_range(7), $urandom,
                  $urandom_range(7), $urandom_range(7));
            model_step();
            tick();
            check_model(c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side arbiter for the 32x32 register file. Merges the in-order ALU/load result stream with out-of-order results from the multi-cycle multiply/divide unit (MDU) into the register file's single write port (`regWrite`/`writeReg`/`writeData`). MDU results are held in a small FIFO until the write port is free. Per-source pending-hit flags let decode stall on operands that are still in flight.

## Interface
- DEPTH, 4, MDU result FIFO entries; power of two, ≥2
- PTR_W, 2, log2(DEPTH)
- clock_in  in  1  clock; all state updates on posedge
- reset  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU/load result valid this cycle; always accepted, no ready
- alu_dest  in  5  ALU destination register
- alu_data  in  32  ALU result
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  FIFO can accept; transfer when mdu_valid && mdu_ready at posedge
- mdu_dest  in  5  MDU destination register
- mdu_data  in  32  MDU result
- query1  in  5  decode rs address, instr[25:21]
- query2  in  5  decode rt address, instr[20:16]
- hit1  out  1  query1 has a write pending (FIFO or output stage)
- hit2  out  1  query2 has a write pending
- regWrite  out  1  register-file write enable, registered
- writeReg  out  5  register-file write address, registered
- writeData  out  32  register-file write data, registered
- fifo_count  out  PTR_W+1  current FIFO occupancy, 0..DEPTH

## Operation
- Write selection at each posedge; ALU has strict priority:
  - alu_valid && alu_dest≠0: output ← ALU result, regWrite=1.
  - Else if FIFO is non-empty: pop the head into the output, regWrite=1.
  - Else: regWrite=0; writeReg/writeData hold their previous values.
- Writes to register 0 are discarded:
  - ALU with dest 0 counts as idle, so the FIFO may drain that cycle.
  - MDU with dest 0 is handshaken (ready honoured) but is not pushed.
- FIFO: circular buffer with rd/wr pointers of PTR_W bits, wrapping modulo DEPTH. The count is held in a separate PTR_W+1-bit register.
- mdu_ready = (fifo_count < DEPTH), decoded from registered state. It is low when full, even in a cycle that also pops.
- Push and pop in the same cycle: both happen, and count is unchanged.
- A pop only takes an entry stored before the current edge. The one exception is the bypass in Configuration.
- Pending hits (combinational):
  - hitN = 1 if queryN≠0 and (any valid FIFO entry has dest==queryN, or regWrite && writeReg==queryN).
  - The ALU input is not included; decode covers it through forwarding.
- Ordering: no dest merging or killing. Entries retire in FIFO order.
- An ALU write to a dest that is also pending in the FIFO is legal. The FIFO write lands later and wins. Avoiding this case is the decode stall's job, via hitN.

## Timing
- Reset (async assert, sync-safe deassert):
  - regWrite=0, writeReg=0, writeData=0.
  - Pointers=0, fifo_count=0.
  - mdu_ready=1 once reset is high; hit1=hit2=0.
  - FIFO storage is not cleared.
- Reset mid-operation drops all buffered MDU results and any output-stage write. No register-file write occurs while reset is low.
- ALU latency: input at edge N → regWrite/writeReg/writeData valid after edge N. The register file commits on the following negedge.
- MDU latency without bypass: at least 2 edges (push at N, pop at N+1), plus 1 edge per pending FIFO entry ahead of it, plus 1 per cycle of ALU priority.
- Starvation is possible under continuous ALU writes. This is acceptable; the MDU stalls on mdu_ready.
- Full FIFO: mdu_ready=0; mdu_valid is ignored and the MDU must hold its data.
- Empty FIFO: no pop; fifo_count never underflows.

## Configuration
- MDU_BYPASS_EN defined:
  - If the FIFO is empty and the ALU is idle (or dest 0), an accepted MDU result with dest≠0 goes straight to the output after the same edge (latency 1) and is not stored.
  - fifo_count is unchanged in that case.
- MDU_BYPASS_EN undefined: every MDU result passes through the FIFO, with a minimum latency of 2.

## Test plan
- Reset low mid-stream with 3 FIFO entries → regWrite=0, fifo_count=0, mdu_ready=1, hit1=hit2=0. After release, no stale write appears.
- alu_valid=1, dest=5, data=0x1234 → after the next edge, regWrite=1, writeReg=5, writeData=0x1234. With alu_dest=0 → regWrite=0.
- ALU valid continuously; push 4 MDU results (dest 8..11) → mdu_ready=0, fifo_count=4. Drop alu_valid → 4 writes 8,9,10,11 in order on consecutive edges.
- FIFO holds dest 7; query1=7, query2=0 → hit1=1, hit2=0. After the write to 7 retires, hit1=0.
- MDU push (dest 3, 0xCAFE) into an empty FIFO with ALU idle → writeReg=3 after 1 edge if MDU_BYPASS_EN, else after 2 edges.
- FIFO at count 3, simultaneous push and pop over 6 cycles → count stays 3, order preserved across pointer wrap.
